// File: rtl/crc_stream_pkg.sv
// Shared definitions for the streaming CRC engine: FSM states, reflection
// helpers and parameter sets for the common CRC standards.
package crc_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // CRC-8
    localparam int unsigned CRC8_WIDTH  = 8;
    localparam logic [7:0]  CRC8_POLY   = 8'h07;
    localparam logic [7:0]  CRC8_INIT   = 8'h00;
    localparam bit          CRC8_REFIN  = 1'b0;
    localparam bit          CRC8_REFOUT = 1'b0;
    localparam logic [7:0]  CRC8_XOROUT = 8'h00;

    // CRC-16/CCITT-FALSE
    localparam int unsigned CCITT_WIDTH  = 16;
    localparam logic [15:0] CCITT_POLY   = 16'h1021;
    localparam logic [15:0] CCITT_INIT   = 16'hFFFF;
    localparam bit          CCITT_REFIN  = 1'b0;
    localparam bit          CCITT_REFOUT = 1'b0;
    localparam logic [15:0] CCITT_XOROUT = 16'h0000;

    // CRC-16/MODBUS
    localparam int unsigned MODBUS_WIDTH  = 16;
    localparam logic [15:0] MODBUS_POLY   = 16'h8005;
    localparam logic [15:0] MODBUS_INIT   = 16'hFFFF;
    localparam bit          MODBUS_REFIN  = 1'b1;
    localparam bit          MODBUS_REFOUT = 1'b1;
    localparam logic [15:0] MODBUS_XOROUT = 16'h0000;

    // CRC-32
    localparam int unsigned CRC32_WIDTH  = 32;
    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam bit          CRC32_REFIN  = 1'b1;
    localparam bit          CRC32_REFOUT = 1'b1;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[3'(i)] = b[3'(7 - i)];
        end
        return r;
    endfunction

    // Reflects the low w bits of v; bits at and above w come back zero.
    function automatic logic [MAX_WIDTH-1:0] reflect_w(input logic [MAX_WIDTH-1:0] v,
                                                      input int unsigned w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                r[6'(i)] = v[6'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte combinational CRC update, MSB-first in the normal (unreflected)
// register domain; input bytes are reflected first when REFIN is set.
module crc_byte_step
    import crc_stream_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h04C11DB7),
    parameter bit               REFIN = 1'b1
) (
    input  logic [WIDTH-1:0] i_crc,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_crc
);

    logic [7:0]       w_byte;
    logic [WIDTH-1:0] w_crc;

    always_comb begin
        w_byte = REFIN ? reflect8(i_byte) : i_byte;
        w_crc  = i_crc ^ (WIDTH'(w_byte) << (WIDTH - 8));
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[WIDTH-1] ? ((w_crc << 1) ^ POLY) : (w_crc << 1);
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: BYTES bytes per beat in, one held result per frame out.
// Optional CRC_STREAM_CHECK_EN adds a crc_expect input and a registered crc_err flag.
module crc_stream
    import crc_stream_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(32'h04C11DB7),
    parameter logic [WIDTH-1:0] INIT   = WIDTH'(32'hFFFFFFFF),
    parameter bit               REFIN  = 1'b1,
    parameter bit               REFOUT = 1'b1,
    parameter logic [WIDTH-1:0] XOROUT = WIDTH'(32'hFFFFFFFF),
    parameter int unsigned      BYTES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [8*BYTES-1:0]           in_data,
    input  logic                         in_last,
    input  logic [$clog2(BYTES+1)-1:0]   in_nbytes,
`ifdef CRC_STREAM_CHECK_EN
    input  logic [WIDTH-1:0]             crc_expect,
    output logic                         crc_err,
`endif
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH-1:0]             crc_out
);

    localparam int unsigned NB_W = $clog2(BYTES + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_res_valid;
    logic [WIDTH-1:0]  r_crc;
    logic [WIDTH-1:0]  r_crc_out;

    logic              w_accept;
    logic [WIDTH-1:0]  w_seed;
    logic [WIDTH-1:0]  w_taps [BYTES+1];
    logic [NB_W-1:0]   w_nsel;
    logic [WIDTH-1:0]  w_crc_step;
    logic [WIDTH-1:0]  w_crc_fin;

    assign w_accept = in_valid & r_in_ready;
    assign w_seed   = (r_state == ST_IDLE) ? INIT : r_crc;

    // Unrolled byte chain; tap k holds the register after bytes 0..k-1.
    assign w_taps[0] = w_seed;
    for (genvar k = 0; k < BYTES; k++) begin : g_step
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;
        if (k == 0) begin : g_first
            assign w_in = w_seed;
        end else begin : g_next
            assign w_in = g_step[k-1].w_out;
        end
        crc_byte_step #(
            .WIDTH (WIDTH),
            .POLY  (POLY),
            .REFIN (REFIN)
        ) u_step (
            .i_crc  (w_in),
            .i_byte (in_data[8*k +: 8]),
            .o_crc  (w_out)
        );
        assign w_taps[k+1] = w_out;
    end

    // Byte count: full beat unless a last beat names a count in 1..BYTES.
    always_comb begin
        w_nsel = NB_W'(BYTES);
        if (in_last && (in_nbytes != '0) && (in_nbytes <= NB_W'(BYTES))) begin
            w_nsel = in_nbytes;
        end
    end

    assign w_crc_step = w_taps[w_nsel];
    assign w_crc_fin  = (REFOUT ? WIDTH'(reflect_w(MAX_WIDTH'(w_crc_step), WIDTH))
                                : w_crc_step) ^ XOROUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags track the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc       <= INIT;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_crc_out   <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt != ST_DONE);
            r_res_valid <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_crc <= w_crc_step;
                if (in_last) begin
                    r_crc_out <= w_crc_fin;
                end
            end else if ((r_state == ST_DONE) && res_ready) begin
                r_crc <= INIT;
            end
        end
    end

`ifdef CRC_STREAM_CHECK_EN
    logic r_crc_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc_err <= 1'b0;
        end else if (w_accept && in_last) begin
            r_crc_err <= (w_crc_fin != crc_expect);
        end
    end

    assign crc_err = r_crc_err;
`endif

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign crc_out   = r_crc_out;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: CRC-32 (4 bytes/beat), CCITT-FALSE (1 byte/beat)
// and MODBUS (8 bytes/beat) instances driven with directed frames.
module tb_crc_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int acc_cyc [3];

    typedef struct {
        logic [63:0] crc;
        bit          err;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        v0, r0, l0, rv0, rr0;
    logic [31:0] d0, co0;
    logic [2:0]  nb0;
    logic        v1, r1, l1, rv1, rr1;
    logic [7:0]  d1;
    logic [0:0]  nb1;
    logic [15:0] co1;
    logic        v2, r2, l2, rv2, rr2;
    logic [63:0] d2;
    logic [3:0]  nb2;
    logic [15:0] co2;
`ifdef CRC_STREAM_CHECK_EN
    logic [31:0] ce0;
    logic [15:0] ce1, ce2;
    logic        er0, er1, er2;
`endif

    crc_stream u_c32 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .in_last(l0), .in_nbytes(nb0),
`ifdef CRC_STREAM_CHECK_EN
        .crc_expect(ce0), .crc_err(er0),
`endif
        .res_valid(rv0), .res_ready(rr0), .crc_out(co0)
    );

    crc_stream #(
        .WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFIN(1'b0),
        .REFOUT(1'b0), .XOROUT(16'h0000), .BYTES(1)
    ) u_c16 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .in_last(l1), .in_nbytes(nb1),
`ifdef CRC_STREAM_CHECK_EN
        .crc_expect(ce1), .crc_err(er1),
`endif
        .res_valid(rv1), .res_ready(rr1), .crc_out(co1)
    );

    crc_stream #(
        .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .REFIN(1'b1),
        .REFOUT(1'b1), .XOROUT(16'h0000), .BYTES(8)
    ) u_mb (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
        .in_last(l2), .in_nbytes(nb2),
`ifdef CRC_STREAM_CHECK_EN
        .crc_expect(ce2), .crc_err(er2),
`endif
        .res_valid(rv2), .res_ready(rr2), .crc_out(co2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [63:0] d,
                          input logic l, input int nb, input logic [63:0] ce);
        case (u)
            0: begin
                v0 = v; d0 = 32'(d); l0 = l; nb0 = 3'(nb);
`ifdef CRC_STREAM_CHECK_EN
                ce0 = 32'(ce);
`endif
            end
            1: begin
                v1 = v; d1 = 8'(d); l1 = l; nb1 = 1'(nb);
`ifdef CRC_STREAM_CHECK_EN
                ce1 = 16'(ce);
`endif
            end
            default: begin
                v2 = v; d2 = d; l2 = l; nb2 = 4'(nb);
`ifdef CRC_STREAM_CHECK_EN
                ce2 = 16'(ce);
`endif
            end
        endcase
    endtask

    function automatic logic get_ready(input int u);
        case (u)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic int qsize(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Offer one beat from posedge+1 and hold it until the DUT accepts it.
    task automatic drive(input int u, input logic [63:0] d, input logic l,
                         input int nb, input logic [63:0] ce);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        set_in(u, 1'b1, d, l, nb, ce);
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = get_ready(u);
            @(posedge clk);
            #1;
            t++;
        end
        chk($sformatf("accept_u%0d", u), 64'(acc), 64'd1);
        if (acc && l) acc_cyc[u] = cyc;
        set_in(u, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 0, ce);
    endtask

    task automatic send_frame(input int u, input string s, input logic [63:0] exp,
                              input logic [63:0] cexp, input int nb_full, input bit stall);
        int   bpb;
        int   idx;
        exp_t e;
        bpb   = (u == 0) ? 4 : ((u == 1) ? 1 : 8);
        idx   = 0;
        e.crc = exp;
        e.err = (cexp != exp);
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        while (idx < s.len()) begin
            int          cnt;
            logic        last;
            logic [63:0] d;
            int          nb;
            last = ((s.len() - idx) <= bpb);
            cnt  = last ? (s.len() - idx) : bpb;
            d    = {8{8'hA5}};
            for (int k = 0; k < cnt; k++) d[8*k +: 8] = s[idx + k];
            nb   = !last ? int'($urandom_range(0, 15)) : ((cnt == bpb) ? nb_full : cnt);
            drive(u, d, last, nb, cexp);
            idx += cnt;
            if (stall && idx == bpb) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int u);
        int t;
        t = 0;
        while (qsize(u) != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    // Monitors: while a result is held it must match the queue head and block input.
    bit pv0, pv1, pv2;

    always @(negedge clk) begin
        if (!rst && rv0) begin
            if (q0.size() == 0) begin
                chk("c32_unexpected_result", 64'(rv0), 64'd0);
            end else begin
                chk("c32_crc", 64'(co0), q0[0].crc);
                chk("c32_in_ready_held", 64'(r0), 64'd0);
                if (!pv0) chk("c32_latency", 64'(cyc), 64'(acc_cyc[0]));
`ifdef CRC_STREAM_CHECK_EN
                chk("c32_crc_err", 64'(er0), 64'(q0[0].err));
`endif
                if (rr0) void'(q0.pop_front());
            end
        end
        pv0 <= rv0 && !rst;
    end

    always @(negedge clk) begin
        if (!rst && rv1) begin
            if (q1.size() == 0) begin
                chk("c16_unexpected_result", 64'(rv1), 64'd0);
            end else begin
                chk("c16_crc", 64'(co1), q1[0].crc);
                chk("c16_in_ready_held", 64'(r1), 64'd0);
                if (!pv1) chk("c16_latency", 64'(cyc), 64'(acc_cyc[1]));
`ifdef CRC_STREAM_CHECK_EN
                chk("c16_crc_err", 64'(er1), 64'(q1[0].err));
`endif
                if (rr1) void'(q1.pop_front());
            end
        end
        pv1 <= rv1 && !rst;
    end

    always @(negedge clk) begin
        if (!rst && rv2) begin
            if (q2.size() == 0) begin
                chk("mb_unexpected_result", 64'(rv2), 64'd0);
            end else begin
                chk("mb_crc", 64'(co2), q2[0].crc);
                chk("mb_in_ready_held", 64'(r2), 64'd0);
                if (!pv2) chk("mb_latency", 64'(cyc), 64'(acc_cyc[2]));
`ifdef CRC_STREAM_CHECK_EN
                chk("mb_crc_err", 64'(er2), 64'(q2[0].err));
`endif
                if (rr2) void'(q2.pop_front());
            end
        end
        pv2 <= rv2 && !rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, 64'd0, 1'b0, 0, 64'd0);
        rr0 = 1'b1; rr1 = 1'b1; rr2 = 1'b1;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_c32_in_ready", 64'(r0), 64'd0);
        chk("rst_c16_in_ready", 64'(r1), 64'd0);
        chk("rst_mb_in_ready", 64'(r2), 64'd0);
        chk("rst_c32_res_valid", 64'(rv0), 64'd0);
        chk("rst_c16_res_valid", 64'(rv1), 64'd0);
        chk("rst_mb_res_valid", 64'(rv2), 64'd0);
        chk("rst_c32_crc_out", 64'(co0), 64'd0);
        chk("rst_c16_crc_out", 64'(co1), 64'd0);
        chk("rst_mb_crc_out", 64'(co2), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_c32_in_ready", 64'(r0), 64'd1);
        chk("post_rst_c16_in_ready", 64'(r1), 64'd1);
        chk("post_rst_mb_in_ready", 64'(r2), 64'd1);

        // "123456789" on each standard; the CRC-32 frame stalls mid-frame
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43926, 0, 1'b1);
        send_frame(1, "123456789", 64'h29B1, 64'h29B1, 0, 1'b0);
        send_frame(2, "123456789", 64'h4B37, 64'h4B37, 0, 1'b0);

        // Full last beat flagged by in_nbytes=0 and by an out-of-range count
        send_frame(0, "12345678", 64'h9AE0DAAF, 64'h9AE0DAAF, 0, 1'b0);
        send_frame(0, "12345678", 64'h9AE0DAAF, 64'h9AE0DAAF, 7, 1'b0);

        // Held result under back-pressure, then a fresh frame after the handoff
        wait_drain(0);
        rr0 = 1'b0;
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43926, 0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rr0 = 1'b1;
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43926, 0, 1'b0);

        // Reset in the middle of a frame discards it
        wait_drain(0);
        wait_drain(1);
        wait_drain(2);
        drive(0, 64'h34333231, 1'b0, 0, 64'd0);
        drive(0, 64'h38373635, 1'b0, 0, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_c32_in_ready", 64'(r0), 64'd0);
        chk("midrst_c32_res_valid", 64'(rv0), 64'd0);
        chk("midrst_c32_crc_out", 64'(co0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_c32_res_valid", 64'(rv0), 64'd0);
        end
        @(posedge clk);
        #1;
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43926, 0, 1'b0);

        // Mismatching expected value must raise crc_err when the check is built in
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43927, 0, 1'b0);
        send_frame(0, "123456789", 64'hCBF43926, 64'hCBF43926, 0, 1'b0);

        wait_drain(0);
        wait_drain(1);
        wait_drain(2);
        chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
